// File: rtl/button_event_queue.sv
// Button event queue: turns edges on debounced input lines into press/release
// events, parks them in per-line pending bits and feeds them through a small FIFO.
module button_event_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       event_valid,
    input  logic                       event_ready,
    output logic [$clog2(WIDTH)-1:0]   event_index,
    output logic                       event_press,
    output logic                       overrun,
    input  logic                       overrun_clear,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [IW-1:0] index;
        logic          press;
    } event_t;

    event_t          mem [DEPTH];
    event_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [WIDTH-1:0] prev;
    logic            settle;
    logic [WIDTH-1:0] pend_press;
    logic [WIDTH-1:0] pend_release;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr_press;
    logic [WIDTH-1:0] clr_release;
    logic            pop;
    logic            push;
    logic            full_eff;
    logic            overrun_set;
    logic            sel_found;
    logic [IW-1:0]   sel_index;
    logic            sel_press;

    // The first cycle after reset only primes prev, so lines already high stay silent.
    assign rise = settle ? '0 : (data_in & ~prev);
    assign fall = settle ? '0 : (~data_in & prev);

    assign event_valid = (count != '0);
    assign pop         = event_valid & event_ready;
    assign full_eff    = (count == CW'(DEPTH)) && !pop;

    // Walk downwards so the lowest pending line is the last one written and wins.
    always_comb begin
        sel_found = 1'b0;
        sel_index = '0;
        sel_press = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_press[i] || pend_release[i]) begin
                sel_found = 1'b1;
                sel_index = IW'(i);
                sel_press = pend_press[i];
            end
        end
    end

    assign push = sel_found && !full_eff;

    always_comb begin
        clr_press   = '0;
        clr_release = '0;
        if (push) begin
            if (sel_press) clr_press[sel_index]   = 1'b1;
            else           clr_release[sel_index] = 1'b1;
        end
    end

    assign overrun_set = |((rise & pend_press & ~clr_press) |
                           (fall & pend_release & ~clr_release));

    assign head        = mem[rd_ptr];
    assign event_index = event_valid ? head.index : '0;
    assign event_press = event_valid & head.press;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev         <= '0;
            settle       <= 1'b1;
            pend_press   <= '0;
            pend_release <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overrun      <= 1'b0;
        end else begin
            prev         <= data_in;
            settle       <= 1'b0;
            // A fresh edge on a line being drained this cycle re-arms its bit.
            pend_press   <= (pend_press & ~clr_press) | rise;
            pend_release <= (pend_release & ~clr_release) | fall;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (overrun_clear)    overrun <= 1'b0;
            else if (overrun_set) overrun <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers define what is valid and the
    // head outputs are gated by event_valid, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= '{index: sel_index, press: sel_press};
    end

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: a scoreboard queue of expected events is
// filled as edges are driven and emptied as the consumer accepts events.
module tb_button_event_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [WIDTH-1:0]         data_in;
    logic                     event_valid;
    logic                     event_ready;
    logic [$clog2(WIDTH)-1:0] event_index;
    logic                     event_press;
    logic                     overrun;
    logic                     overrun_clear;
    logic [$clog2(DEPTH):0]   count;

    typedef struct {
        int idx;
        bit press;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    button_event_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_index   (event_index),
        .event_press   (event_press),
        .overrun       (overrun),
        .overrun_clear (overrun_clear),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_event(input int idx, input bit press);
        exp_q.push_back('{idx, press});
    endtask

    task automatic wait_drain(input int max_cycles, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || event_valid !== 1'b0) && n < max_cycles) begin
            tick(1);
            n++;
        end
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid_low"}, 32'(event_valid), 32'd0);
    endtask

    // Accepted events are compared against the scoreboard on the falling edge,
    // where ready and valid are the values the next rising edge will act on.
    always @(negedge clk) begin
        if (reset === 1'b0 && event_valid === 1'b1 && event_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(event_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ev_index", 32'(event_index), 32'(e.idx));
                check("ev_press", 32'(event_press), 32'(e.press));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        data_in       = 8'h05;
        event_ready   = 1'b1;
        overrun_clear = 1'b0;
        tick(3);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_index", 32'(event_index), 32'd0);
        check("rst_press", 32'(event_press), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Lines held high through reset release must not produce events.
        reset = 1'b0;
        tick(6);
        check("held_high_valid", 32'(event_valid), 32'd0);
        check("held_high_count", 32'(count), 32'd0);

        data_in = 8'h04;
        expect_event(0, 1'b0);
        wait_drain(20, "release0");

        data_in = 8'h00;
        expect_event(2, 1'b0);
        wait_drain(20, "release2");

        // Two simultaneous presses: lowest line first, two-cycle latency.
        data_in = 8'h81;
        expect_event(0, 1'b1);
        expect_event(7, 1'b1);
        tick(1);
        check("lat_t0_valid", 32'(event_valid), 32'd0);
        tick(1);
        check("lat_t1_valid", 32'(event_valid), 32'd1);
        check("lat_t1_index", 32'(event_index), 32'd0);
        check("lat_t1_press", 32'(event_press), 32'd1);
        tick(1);
        check("lat_t2_valid", 32'(event_valid), 32'd1);
        check("lat_t2_index", 32'(event_index), 32'd7);
        check("lat_t2_press", 32'(event_press), 32'd1);
        tick(1);
        check("lat_t3_valid", 32'(event_valid), 32'd0);

        data_in = 8'h00;
        expect_event(0, 1'b0);
        expect_event(7, 1'b0);
        wait_drain(20, "release0_7");

        // Ten edges on line 3 with the consumer stalled.
        event_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_in = (i % 2 == 0) ? 8'h08 : 8'h00;
            tick(1);
        end
        for (int i = 0; i < 3; i++) begin
            expect_event(3, 1'b1);
            expect_event(3, 1'b0);
        end
        check("sat_count", 32'(count), 32'd4);
        check("sat_overrun", 32'(overrun), 32'd1);
        check("sat_index", 32'(event_index), 32'd3);
        check("sat_press", 32'(event_press), 32'd1);
        tick(2);
        check("stall_index_stable", 32'(event_index), 32'd3);
        check("stall_press_stable", 32'(event_press), 32'd1);

        // Full FIFO drained while pending bits refill it in the same cycle.
        event_ready = 1'b1;
        tick(1);
        check("full_pushpop_count1", 32'(count), 32'd4);
        tick(1);
        check("full_pushpop_count2", 32'(count), 32'd4);
        tick(1);
        check("drain_count3", 32'(count), 32'd3);
        wait_drain(20, "sat_drain");
        check("sat_drain_count", 32'(count), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        overrun_clear = 1'b1;
        tick(1);
        check("overrun_cleared", 32'(overrun), 32'd0);
        overrun_clear = 1'b0;

        // Clear arrives together with a fresh overrun and must win.
        event_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_in = (i % 2 == 0) ? 8'h08 : 8'h00;
            overrun_clear = (i == 9);
            tick(1);
            if (i == 8) check("overrun_set_again", 32'(overrun), 32'd1);
        end
        check("clear_beats_set", 32'(overrun), 32'd0);
        overrun_clear = 1'b0;
        tick(1);
        check("clear_stays_low", 32'(overrun), 32'd0);
        for (int i = 0; i < 3; i++) begin
            expect_event(3, 1'b1);
            expect_event(3, 1'b0);
        end
        event_ready = 1'b1;
        wait_drain(30, "clr_drain");

        // Reset mid-operation discards queued and pending events.
        event_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = (i % 2 == 0) ? 8'h20 : 8'h00;
            tick(1);
        end
        expect_event(5, 1'b1);
        expect_event(5, 1'b0);
        expect_event(5, 1'b1);
        check("pre_reset_count", 32'(count), 32'd3);
        reset = 1'b1;
        tick(1);
        exp_q.delete();
        check("mid_reset_count", 32'(count), 32'd0);
        check("mid_reset_valid", 32'(event_valid), 32'd0);
        reset       = 1'b0;
        event_ready = 1'b1;
        tick(8);
        check("post_reset_valid", 32'(event_valid), 32'd0);
        check("post_reset_count", 32'(count), 32'd0);
        check("post_reset_overrun", 32'(overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_queue.md
BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of debounced input lines, range 2..32.
REQ-002 SHALL have parameter DEPTH, default 4: event FIFO entries, a power of two, range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_in, input, WIDTH bits: debounced active-high levels, already synchronous to clk.
REQ-006 SHALL have port event_valid, output, 1 bit: the FIFO head holds an event.
REQ-007 SHALL have port event_ready, input, 1 bit: the consumer accepts the head event.
REQ-008 SHALL have port event_index, output, clog2(WIDTH) bits: the line number of the head event.
REQ-009 SHALL have port event_press, output, 1 bit: 1 = rising edge (press), 0 = falling edge (release).
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag indicating an event was lost.
REQ-011 SHALL have port overrun_clear, input, 1 bit: clears overrun.
REQ-012 SHALL have port count, output, clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-013 SHALL register data_in into prev every cycle; per-bit rise = data_in & ~prev and fall = ~data_in & prev.
REQ-014 SHALL suppress edge detection on the first cycle after reset deasserts, so that prev loads data_in and lines already high produce no event.
REQ-015 SHALL keep per-line pend_press and pend_release bits; a detected edge SHALL set the matching bit at the same clk edge that samples it.
REQ-016 SHALL set overrun when an edge arrives on a line whose matching pend bit is already set and not being cleared that cycle; the pend bit SHALL stay set.
REQ-017 SHALL have a scanner that, when the FIFO is not full, selects one pending event per cycle: the lowest line index with any pend bit set, and press before release on the same line.
REQ-018 SHALL push the selected event into the FIFO and clear its pend bit at the same clk edge.
REQ-019 SHALL give a 2-cycle latency: a data_in change sampled at edge t SHALL appear as event_valid after edge t+1, provided the FIFO is empty and no lower-index line is pending.
REQ-020 SHALL complete a pop when event_valid & event_ready at a clk edge; event_index and event_press SHALL be stable while event_valid=1 and event_ready=0.
REQ-021 SHALL make event_valid depend only on registered state, with no combinational path from event_ready.
REQ-022 SHALL allow a simultaneous push and pop when full, because the scanner SHALL treat "full and popping" as not full; count stays unchanged in that case.
REQ-023 SHALL wrap the FIFO pointers modulo DEPTH; count SHALL range 0..DEPTH exactly.
REQ-024 SHALL hold pending events with no loss while the FIFO is full; loss SHALL occur only per REQ-016.
REQ-025 SHALL give overrun_clear priority over a same-cycle overrun set, with that set being dropped.

Reset
REQ-026 SHALL, while reset=1 at a clk edge, clear the FIFO pointers, count=0, event_valid=0, event_index=0, event_press=0, overrun=0, all pend bits=0, and prev=0, and arm the first-cycle suppression of REQ-014.
REQ-027 SHALL, when reset is asserted mid-operation, discard all queued and pending events; there is no partial-drain.

Verification
REQ-028 SHALL verify: reset with data_in=0x05 held, release -> no event ever; then data_in=0x04 -> exactly one event {index 0, press 0}.
REQ-029 SHALL verify: data_in 0x00 -> 0x81 in one cycle, event_ready=1 -> events {0,press} then {7,press} on consecutive cycles, first valid 2 cycles after the change.
REQ-030 SHALL verify: event_ready=0, toggle line 3 five times (10 edges, DEPTH=4) -> count saturates at 4, line 3 pend bits both set, overrun=1; then ready=1 -> 6 events drain, then valid=0.
REQ-031 SHALL verify: FIFO full, ready=1 continuously with a new edge pending -> push and pop in the same cycle, count stays 4, no event lost.
REQ-032 SHALL verify: overrun_clear=1 in the same cycle as a new overrun condition -> overrun=0 next cycle.
REQ-033 SHALL verify: reset pulsed with count=3 and pend bits set -> count=0, valid=0 next cycle, and no stale event after release.
